// File: rtl/us_timeout_ctrl_pkg.sv
// Shared timer definitions for the microsecond timeout controller:
// FSM state encoding, default counter width and the clk-per-us ratio
// of the 50 MHz system clock.
package us_timeout_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned CLK_PER_US = 50;

endpackage

// File: rtl/us_timeout_ctrl_edge_det.sv
// tick_edge_det: synchronises the 1 us toggle from the timebase, converts
// each transition into a 1-clk strobe and watches for a stalled timebase.
// Ports:
//   clk_i, rst_i    system clock, asynchronous active-high reset
//   tick_toggle_i   1 us toggle (every edge = 1 us)
//   us_pulse_o      1-clk strobe per detected toggle edge
//   tick_fault_o    set after GAP_MAX clks with no edge, cleared by next edge
module tick_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_MAX     = 60,
  parameter int unsigned GAP_W       = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_toggle_i,
  output logic us_pulse_o,
  output logic tick_fault_o
);

  localparam int unsigned ARM_LAST = SYNC_STAGES + 1;
  localparam int unsigned ARM_W    = $clog2(ARM_LAST + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MAX);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [ARM_W-1:0]       arm_q;
  logic [GAP_W-1:0]       gap_q;
  logic                   armed;
  logic                   edge_seen;

  // The chain resets to 0, so whatever level the input holds at reset
  // would look like an edge once it reaches the end of the chain; the
  // detector stays disarmed until that artefact has flushed through.
  assign armed     = (arm_q == ARM_W'(ARM_LAST));
  assign edge_seen = armed & (sync_q[SYNC_STAGES-1] ^ prev_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      arm_q        <= '0;
      gap_q        <= '0;
      us_pulse_o   <= 1'b0;
      tick_fault_o <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_toggle_i};
      prev_q     <= sync_q[SYNC_STAGES-1];
      us_pulse_o <= edge_seen;
      if (!armed) begin
        arm_q <= arm_q + ARM_W'(1);
      end
      // Gap counter clears on the same edge that raises us_pulse_o, so the
      // fault drops together with the strobe of the reviving edge.
      if (edge_seen) begin
        gap_q        <= '0;
        tick_fault_o <= 1'b0;
      end else if (gap_q != GAP_LIMIT) begin
        gap_q <= gap_q + GAP_W'(1);
        if (gap_q + GAP_W'(1) == GAP_LIMIT) begin
          tick_fault_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/us_timeout_ctrl.sv
// us_timeout_ctrl: consumer of the 1 us timebase toggle. Produces a 1-clk
// us strobe and runs one programmable microsecond timeout with
// start/kick/stop control; also flags a stalled timebase.
// Ports:
//   clk_i, rst_i     50 MHz clock, asynchronous active-high reset
//   tick_toggle_i    1 us toggle from the timebase
//   start_i          load timeout_us_i, clear elapsed, run
//   timeout_us_i     timeout length in us, sampled on start_i
//   kick_i           clear elapsed in RUN, limit kept
//   stop_i           abort to IDLE, elapsed held
//   us_pulse_o       1-clk strobe per toggle edge
//   busy_o           state == RUN
//   expired_o        state == EXPIRED
//   expire_pulse_o   1-clk strobe on entry to EXPIRED
//   elapsed_us_o     us counted since last start/kick
//   tick_fault_o     timebase stalled
module us_timeout_ctrl
  import us_timeout_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_MAX     = 60,
  parameter int unsigned GAP_W       = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_toggle_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] timeout_us_i,
  input  logic             kick_i,
  input  logic             stop_i,
  output logic             us_pulse_o,
  output logic             busy_o,
  output logic             expired_o,
  output logic             expire_pulse_o,
  output logic [CNT_W-1:0] elapsed_us_o,
  output logic             tick_fault_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] elapsed_inc;
  logic             expire_q, expire_d;

  tick_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .GAP_MAX    (GAP_MAX),
    .GAP_W      (GAP_W)
  ) u_edge (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tick_toggle_i(tick_toggle_i),
    .us_pulse_o   (us_pulse_o),
    .tick_fault_o (tick_fault_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      elapsed_q <= '0;
      limit_q   <= '0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      limit_q   <= limit_d;
      expire_q  <= expire_d;
    end
  end

  // Priority start > stop > kick > tick; a tick arriving with any control
  // pulse falls through the else-chain and is therefore never counted.
  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    limit_d     = limit_q;
    expire_d    = 1'b0;
    elapsed_inc = elapsed_q + ONE;
    if (start_i) begin
      elapsed_d = '0;
      limit_d   = timeout_us_i;
      if (timeout_us_i == '0) begin
        state_d  = ST_EXPIRED;
        expire_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (stop_i) begin
      state_d = ST_IDLE;
    end else if (kick_i) begin
      if (state_q == ST_RUN) begin
        elapsed_d = '0;
      end
    end else if (us_pulse_o && state_q == ST_RUN) begin
      // In RUN elapsed < limit, so the increment cannot wrap.
      elapsed_d = elapsed_inc;
      if (elapsed_inc == limit_q) begin
        state_d  = ST_EXPIRED;
        expire_d = 1'b1;
      end
    end
  end

  assign busy_o         = (state_q == ST_RUN);
  assign expired_o      = (state_q == ST_EXPIRED);
  assign expire_pulse_o = expire_q;
  assign elapsed_us_o   = elapsed_q;

endmodule
